// File: rtl/grid_defs_pkg.sv
// -----------------------------------------------------------------------------
// grid_defs : shared definitions for the world-grid rebuild logic.
// Cell codes written into the grid RAM, default grid geometry and the
// sequencer state encoding.
// -----------------------------------------------------------------------------
package grid_defs;

    // Cell codes stored in the world grid RAM
    localparam logic [1:0] CELL_WORLD = 2'b00;
    localparam logic [1:0] CELL_FOOD  = 2'b01;
    localparam logic [1:0] CELL_SNAKE = 2'b10;

    // Default grid geometry
    localparam int GRID_W   = 16;
    localparam int GRID_H   = 16;
    localparam int MAX_SEGS = 10;
    localparam int ADDR_W   = 8;

    // Frame rebuild sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SNAKE = 3'd2,
        FOOD  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/grid_update_sequencer_seg_select.sv
// -----------------------------------------------------------------------------
// grid_seg_select : picks either segment seg_idx of the snapshot or the food
// coordinate, checks it against the grid bounds and forms the RAM address
// y*GRID_W + x at ADDR_W bits (a shift when GRID_W is a power of two).
// Purely combinational.
// -----------------------------------------------------------------------------
module grid_seg_select #(
    parameter int GRID_W   = grid_defs::GRID_W,
    parameter int GRID_H   = grid_defs::GRID_H,
    parameter int MAX_SEGS = grid_defs::MAX_SEGS,
    parameter int ADDR_W   = grid_defs::ADDR_W
) (
    input  logic [8*MAX_SEGS-1:0] snake,
    input  logic [3:0]            seg_idx,
    input  logic                  sel_food,
    input  logic [3:0]            food_x,
    input  logic [3:0]            food_y,
    output logic                  in_range,
    output logic [ADDR_W-1:0]     cell_addr
);

    localparam logic [31:0] W_LIM = 32'(GRID_W);
    localparam logic [31:0] H_LIM = 32'(GRID_H);
    localparam logic [31:0] S_LIM = 32'(MAX_SEGS);

    logic [MAX_SEGS-1:0][7:0] seg_arr_s;
    logic [3:0]               cell_x_s;
    logic [3:0]               cell_y_s;
    logic [ADDR_W-1:0]        x_ext_s;
    logic [ADDR_W-1:0]        y_ext_s;
    logic [ADDR_W-1:0]        row_base_s;

    assign seg_arr_s = snake;

    // Select the coordinate being written: the food cell or segment seg_idx
    always_comb begin
        {cell_y_s, cell_x_s} = 8'h00;
        if (sel_food) begin
            {cell_y_s, cell_x_s} = {food_y, food_x};
        end else if ({28'd0, seg_idx} < S_LIM) begin
            {cell_y_s, cell_x_s} = seg_arr_s[seg_idx];
        end else begin
            {cell_y_s, cell_x_s} = 8'h00;
        end
    end

    // Coordinates beyond the grid are never wrapped onto a valid cell
    assign in_range = ({28'd0, cell_x_s} < W_LIM) && ({28'd0, cell_y_s} < H_LIM);

    assign x_ext_s = ADDR_W'(cell_x_s);
    assign y_ext_s = ADDR_W'(cell_y_s);

    generate
        if ((GRID_W & (GRID_W - 1)) == 0) begin : g_row_shift
            assign row_base_s = y_ext_s << $clog2(GRID_W);
        end else begin : g_row_mult
            localparam logic [ADDR_W-1:0] W_A = ADDR_W'(GRID_W);
            assign row_base_s = y_ext_s * W_A;
        end
    endgenerate

    assign cell_addr = row_base_s + x_ext_s;

endmodule

// File: rtl/grid_update_sequencer.sv
// -----------------------------------------------------------------------------
// grid_update_sequencer : rebuilds the world grid RAM once per game tick.
// On an accepted tick the snake and food inputs are snapshotted, every cell
// is cleared, each snake segment is written, then the food cell is written
// last (so food on a snake cell reads as food). All outputs are registered;
// RAM writes lag the FSM state by one cycle.
//
// Build option: define SELF_HIT_DETECT_EN to add the head-vs-body comparator
// driving self_hit; without it self_hit is tied low.
// -----------------------------------------------------------------------------
module grid_update_sequencer #(
    parameter int GRID_W   = grid_defs::GRID_W,
    parameter int GRID_H   = grid_defs::GRID_H,
    parameter int MAX_SEGS = grid_defs::MAX_SEGS,
    parameter int ADDR_W   = grid_defs::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_req,
    output logic                  tick_ack,
    input  logic [8*MAX_SEGS-1:0] snake_in,
    input  logic [3:0]            seg_count,
    input  logic [3:0]            food_x,
    input  logic [3:0]            food_y,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [1:0]            wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic                  range_err,
    output logic                  self_hit
);

    import grid_defs::*;

    localparam int                CELLS     = GRID_W * GRID_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [3:0]        N_MAX     = 4'(MAX_SEGS);

    state_e                state_r;
    state_e                state_s;
    logic [ADDR_W-1:0]     clr_cnt_r;
    logic [ADDR_W-1:0]     clr_cnt_s;
    logic [3:0]            seg_idx_r;
    logic [3:0]            seg_idx_s;
    logic [3:0]            n_r;
    logic [3:0]            n_cap_s;
    logic [8*MAX_SEGS-1:0] snake_r;
    logic [3:0]            food_x_r;
    logic [3:0]            food_y_r;
    logic                  capture_s;
    logic                  sel_food_s;
    logic                  in_range_s;
    logic [ADDR_W-1:0]     cell_addr_s;

    logic                  tick_ack_r,  tick_ack_s;
    logic                  wr_en_r,     wr_en_s;
    logic [ADDR_W-1:0]     wr_addr_r,   wr_addr_s;
    logic [1:0]            wr_data_r,   wr_data_s;
    logic                  busy_r,      busy_s;
    logic                  done_r,      done_s;
    logic                  overrun_r,   overrun_s;
    logic                  range_err_r, range_err_s;

    assign n_cap_s    = (seg_count > N_MAX) ? N_MAX : seg_count;
    assign sel_food_s = (state_r == FOOD);

    grid_seg_select #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .MAX_SEGS (MAX_SEGS),
        .ADDR_W   (ADDR_W)
    ) u_seg_select (
        .snake     (snake_r),
        .seg_idx   (seg_idx_r),
        .sel_food  (sel_food_s),
        .food_x    (food_x_r),
        .food_y    (food_y_r),
        .in_range  (in_range_s),
        .cell_addr (cell_addr_s)
    );

    // Next-state and next-output logic of the rebuild sequencer
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        seg_idx_s   = seg_idx_r;
        capture_s   = 1'b0;
        tick_ack_s  = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        done_s      = 1'b0;
        busy_s      = (state_r != IDLE);
        range_err_s = range_err_r;
        // A request seen mid-frame (after the accept cycle, before DONE) is dropped
        overrun_s   = overrun_r |
                      (tick_req & ~tick_ack_r &
                       ((state_r == CLEAR) | (state_r == SNAKE) | (state_r == FOOD)));

        case (state_r)
            IDLE: begin
                if (tick_req) begin
                    state_s    = CLEAR;
                    tick_ack_s = 1'b1;
                    capture_s  = 1'b1;
                    clr_cnt_s  = '0;
                    seg_idx_s  = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_cnt_r;
                wr_data_s = CELL_WORLD;
                if (clr_cnt_r == LAST_ADDR) begin
                    clr_cnt_s = '0;
                    seg_idx_s = 4'd0;
                    state_s   = (n_r == 4'd0) ? FOOD : SNAKE;
                end else begin
                    clr_cnt_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            SNAKE: begin
                wr_en_s   = in_range_s;
                wr_addr_s = cell_addr_s;
                wr_data_s = CELL_SNAKE;
                if (!in_range_s) begin
                    range_err_s = 1'b1;
                end else begin
                    range_err_s = range_err_r;
                end
                if (seg_idx_r == (n_r - 4'd1)) begin
                    state_s = FOOD;
                end else begin
                    seg_idx_s = seg_idx_r + 4'd1;
                end
            end
            FOOD: begin
                wr_en_s   = in_range_s;
                wr_addr_s = cell_addr_s;
                wr_data_s = CELL_FOOD;
                if (!in_range_s) begin
                    range_err_s = 1'b1;
                end else begin
                    range_err_s = range_err_r;
                end
                state_s = DONE;
            end
            DONE: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            clr_cnt_r   <= '0;
            seg_idx_r   <= 4'd0;
            tick_ack_r  <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 2'b00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            clr_cnt_r   <= clr_cnt_s;
            seg_idx_r   <= seg_idx_s;
            tick_ack_r  <= tick_ack_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            overrun_r   <= overrun_s;
            range_err_r <= range_err_s;
        end
    end

    // Snapshot of the game inputs taken on accept; later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snake_r  <= '0;
            n_r      <= 4'd0;
            food_x_r <= 4'd0;
            food_y_r <= 4'd0;
        end else if (capture_s) begin
            snake_r  <= snake_in;
            n_r      <= n_cap_s;
            food_x_r <= food_x;
            food_y_r <= food_y;
        end else begin
            snake_r  <= snake_r;
            n_r      <= n_r;
            food_x_r <= food_x_r;
            food_y_r <= food_y_r;
        end
    end

`ifdef SELF_HIT_DETECT_EN
    logic [MAX_SEGS-1:0][7:0] snap_arr_s;
    logic [7:0]               head_s;
    logic [7:0]               body_s;
    logic                     self_hit_r;
    logic                     self_hit_s;

    assign snap_arr_s = snake_r;

    // Head is the last valid snapshot segment; body is the segment being written
    always_comb begin
        head_s = 8'h00;
        body_s = 8'h00;
        if (n_r != 4'd0) begin
            head_s = snap_arr_s[n_r - 4'd1];
        end else begin
            head_s = 8'h00;
        end
        if (seg_idx_r < N_MAX) begin
            body_s = snap_arr_s[seg_idx_r];
        end else begin
            body_s = 8'h00;
        end
    end

    // Self-hit flag: cleared on accept, set by the first body/head match
    always_comb begin
        self_hit_s = self_hit_r;
        if (capture_s) begin
            self_hit_s = 1'b0;
        end else if ((state_r == SNAKE) && (seg_idx_r < (n_r - 4'd1)) && (body_s == head_s)) begin
            self_hit_s = 1'b1;
        end else begin
            self_hit_s = self_hit_r;
        end
    end

    // Self-hit flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            self_hit_r <= 1'b0;
        end else begin
            self_hit_r <= self_hit_s;
        end
    end

    assign self_hit = self_hit_r;
`else
    assign self_hit = 1'b0;
`endif

    assign tick_ack  = tick_ack_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overrun   = overrun_r;
    assign range_err = range_err_r;

endmodule

// File: tb/tb_grid_update_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for grid_update_sequencer. A 16x16 instance carries most frames;
// a 15-wide instance exercises out-of-range columns. Expected RAM write
// streams are queued when a frame is accepted and popped by negedge monitors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grid_update_sequencer;

    typedef struct packed {
        logic [7:0] a;
        logic [1:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_req, tick_req15;
    logic [79:0] snake_in;
    logic [3:0]  seg_count, food_x, food_y;

    logic        tick_ack, wr_en, busy, done, overrun, range_err, self_hit;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        tick_ack15, wr_en15, busy15, done15, overrun15, range_err15, self_hit15;
    logic [7:0]  wr_addr15;
    logic [1:0]  wr_data15;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          snake_wr = 0;
    logic [7:0]  last_addr = 8'd0;
    logic [1:0]  last_data = 2'd0;
    wr_t         exp_q[$];
    wr_t         exp15_q[$];

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc++;

    grid_update_sequencer #(.GRID_W(16), .GRID_H(16), .MAX_SEGS(10), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .tick_req(tick_req), .tick_ack(tick_ack),
        .snake_in(snake_in), .seg_count(seg_count), .food_x(food_x), .food_y(food_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .overrun(overrun), .range_err(range_err), .self_hit(self_hit)
    );

    grid_update_sequencer #(.GRID_W(15), .GRID_H(16), .MAX_SEGS(10), .ADDR_W(8)) dut15 (
        .clk(clk), .reset(reset), .tick_req(tick_req15), .tick_ack(tick_ack15),
        .snake_in(snake_in), .seg_count(seg_count), .food_x(food_x), .food_y(food_y),
        .wr_en(wr_en15), .wr_addr(wr_addr15), .wr_data(wr_data15), .busy(busy15), .done(done15),
        .overrun(overrun15), .range_err(range_err15), .self_hit(self_hit15)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor for the 16-wide instance: pop and compare every RAM write
    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            if (tick_ack) ack_cnt++;
            if (wr_en) begin
                last_addr = wr_addr;
                last_data = wr_data;
                if (wr_data == 2'b10) snake_wr++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra: actual addr=%0d data=%0d, required no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.a !== wr_addr || e.d !== wr_data) begin
                        errors++;
                        $display("FAIL wr_stream: actual addr=%0d data=%0d, required addr=%0d data=%0d",
                                 wr_addr, wr_data, e.a, e.d);
                    end
                end
            end
        end
    end

    // Monitor for the 15-wide instance
    always @(negedge clk) begin
        wr_t e;
        if (reset && wr_en15) begin
            checks++;
            if (exp15_q.size() == 0) begin
                errors++;
                $display("FAIL wr15_extra: actual addr=%0d data=%0d, required no write", wr_addr15, wr_data15);
            end else begin
                e = exp15_q.pop_front();
                if (e.a !== wr_addr15 || e.d !== wr_data15) begin
                    errors++;
                    $display("FAIL wr15_stream: actual addr=%0d data=%0d, required addr=%0d data=%0d",
                             wr_addr15, wr_data15, e.a, e.d);
                end
            end
        end
    end

    // Reference frame: clear all cells, in-range segments, then food
    task automatic push_frame(input bit sel, input logic [79:0] snk, input logic [3:0] cnt,
                              input logic [3:0] fx, input logic [3:0] fy, input int gw);
        wr_t w;
        int  n;
        n = (cnt > 4'd10) ? 10 : int'(cnt);
        for (int a = 0; a < gw * 16; a++) begin
            w.a = 8'(a);
            w.d = 2'b00;
            if (sel) exp15_q.push_back(w); else exp_q.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            logic [7:0] s;
            s = snk[i*8 +: 8];
            if (int'(s[3:0]) < gw) begin
                w.a = 8'(int'(s[7:4]) * gw + int'(s[3:0]));
                w.d = 2'b10;
                if (sel) exp15_q.push_back(w); else exp_q.push_back(w);
            end
        end
        if (int'(fx) < gw) begin
            w.a = 8'(int'(fy) * gw + int'(fx));
            w.d = 2'b01;
            if (sel) exp15_q.push_back(w); else exp_q.push_back(w);
        end
    endtask

    task automatic run_frame(input bit sel, input logic [79:0] snk, input logic [3:0] cnt,
                             input logic [3:0] fx, input logic [3:0] fy,
                             input int abort_at, input bit pulse_mid, input string tag);
        int a_cyc, gw, n, to;
        gw = sel ? 15 : 16;
        n  = (cnt > 4'd10) ? 10 : int'(cnt);
        snake_in = snk; seg_count = cnt; food_x = fx; food_y = fy;
        if (sel) tick_req15 = 1'b1; else tick_req = 1'b1;
        to = 0;
        do begin
            @(posedge clk); #1; to++;
        end while (!(sel ? tick_ack15 : tick_ack) && to < 50);
        tick_req = 1'b0; tick_req15 = 1'b0;
        checks++;
        if (!(sel ? tick_ack15 : tick_ack)) begin
            errors++;
            $display("FAIL %s_ack: actual no ack, required ack within 50 cycles", tag);
            return;
        end
        a_cyc = cyc;
        push_frame(sel, snk, cnt, fx, fy, gw);
        // Inputs move after accept; the frame must follow the snapshot
        snake_in = ~snk; food_x = ~fx; food_y = ~fy; seg_count = 4'd2;
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge clk);
            #1 reset = 1'b0;
            exp_q.delete(); exp15_q.delete();
            #1;
            chk({tag, "_rst_wr_en"},   32'(wr_en),     32'd0);
            chk({tag, "_rst_wr_addr"}, 32'(wr_addr),   32'd0);
            chk({tag, "_rst_wr_data"}, 32'(wr_data),   32'd0);
            chk({tag, "_rst_busy"},    32'(busy),      32'd0);
            chk({tag, "_rst_overrun"}, 32'(overrun),   32'd0);
            chk({tag, "_rst_rng15"},   32'(range_err15), 32'd0);
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
            return;
        end
        to = 0;
        do begin
            @(posedge clk); #1; to++;
            if (to == 1) chk({tag, "_busy"}, 32'(sel ? busy15 : busy), 32'd1);
            if (pulse_mid && to == 20) tick_req = 1'b1;
            else if (pulse_mid && to == 21) tick_req = 1'b0;
        end while (!(sel ? done15 : done) && to < 400);
        chk({tag, "_latency"}, 32'(cyc - a_cyc), 32'(gw * 16 + n + 2));
        chk({tag, "_left"}, 32'(sel ? exp15_q.size() : exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 32'(sel ? busy15 : busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(sel ? done15 : done), 32'd0);
    endtask

    logic [79:0] v_t1, v_max;
    int          ack0;

    initial begin
        reset = 1'b0; tick_req = 1'b0; tick_req15 = 1'b0;
        snake_in = '0; seg_count = 4'd0; food_x = 4'd0; food_y = 4'd0;
        v_t1 = {56'd0, 8'h13, 8'h12, 8'h11};
        for (int i = 0; i < 10; i++) v_max[i*8 +: 8] = 8'h90 + 8'(i);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en",     32'(wr_en),     32'd0);
        chk("rst_wr_addr",   32'(wr_addr),   32'd0);
        chk("rst_wr_data",   32'(wr_data),   32'd0);
        chk("rst_tick_ack",  32'(tick_ack),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_self_hit",  32'(self_hit),  32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Three segments at 17,18,19 and food at 51
        snake_wr = 0;
        run_frame(1'b0, v_t1, 4'd3, 4'd3, 4'd3, 0, 1'b0, "t1");
        chk("t1_snake_writes", 32'(snake_wr), 32'd3);
        chk("t1_last_addr", 32'(last_addr), 32'd51);
        chk("t1_last_data", 32'(last_data), 32'd1);
        chk("t1_overrun", 32'(overrun), 32'd0);

        // No segments: CLEAR straight to FOOD at addr 5
        snake_wr = 0;
        run_frame(1'b0, v_t1, 4'd0, 4'd5, 4'd0, 0, 1'b0, "t2");
        chk("t2_snake_writes", 32'(snake_wr), 32'd0);
        chk("t2_last_addr", 32'(last_addr), 32'd5);

        // Request pulse mid-CLEAR: ignored but flagged
        ack0 = ack_cnt;
        run_frame(1'b0, v_t1, 4'd3, 4'd3, 4'd3, 0, 1'b1, "t3");
        chk("t3_acks", 32'(ack_cnt - ack0), 32'd1);
        chk("t3_overrun", 32'(overrun), 32'd1);

        // Food on a snake cell (37): written last
        run_frame(1'b0, {64'd0, 8'h25, 8'h24}, 4'd2, 4'd5, 4'd2, 0, 1'b0, "t4");
        chk("t4_last_addr", 32'(last_addr), 32'd37);
        chk("t4_last_data", 32'(last_data), 32'd1);

        // seg_count beyond MAX_SEGS clamps to 10 segments
        snake_wr = 0;
        run_frame(1'b0, v_max, 4'd15, 4'd0, 4'd15, 0, 1'b0, "tmax");
        chk("tmax_snake_writes", 32'(snake_wr), 32'd10);

        // 15-wide grid: column 15 is out of range and skipped
        run_frame(1'b1, {56'd0, 8'h40, 8'h3F, 8'h21}, 4'd3, 4'd7, 4'd1, 0, 1'b0, "t5");
        chk("t5_range_err15", 32'(range_err15), 32'd1);
        chk("t5_range_err16", 32'(range_err), 32'd0);

        // Head (2,2) also present in the body
        run_frame(1'b0, {56'd0, 8'h22, 8'h23, 8'h22}, 4'd3, 4'd0, 4'd0, 0, 1'b0, "tsh");
`ifdef SELF_HIT_DETECT_EN
        chk("tsh_self_hit", 32'(self_hit), 32'd1);
`else
        chk("tsh_self_hit", 32'(self_hit), 32'd0);
`endif
        run_frame(1'b0, v_t1, 4'd3, 4'd3, 4'd3, 0, 1'b0, "tsh2");
        chk("tsh2_self_hit", 32'(self_hit), 32'd0);

        // Reset during SNAKE, then a full frame
        run_frame(1'b0, v_t1, 4'd3, 4'd3, 4'd3, 257, 1'b0, "t6a");
        snake_wr = 0;
        run_frame(1'b0, v_t1, 4'd3, 4'd3, 4'd3, 0, 1'b0, "t6b");
        chk("t6b_snake_writes", 32'(snake_wr), 32'd3);
        chk("t6b_last_addr", 32'(last_addr), 32'd51);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
